// File: rtl/axis_spi_cfg_tx_if.sv
// Valid/ready word stream used for both the command input and the readback output.
interface axis_spi_cfg_tx_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_cfg_tx.sv
// Stream-to-SPI (mode 0) command shifter with optional readback; one frame per accepted command.
// Commands stall (tready low) while a frame is in flight or a readback word waits for its consumer.
module axis_spi_cfg_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  axis_spi_cfg_tx_if.slave  s_axis,
  axis_spi_cfg_tx_if.master m_axis,
  output logic              spi_csn,
  output logic              spi_sck,
  output logic              spi_sdo,
  input  logic              spi_sdi
);

  localparam int BW   = $clog2(DATA_WIDTH) + 1;
  localparam int PW   = $clog2(CLK_DIV) + 1;
  localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                             : ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [DATA_WIDTH-2:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  rd_q, rd_d;
  logic                  csn_q, csn_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic [DATA_WIDTH-1:0] mdat_q, mdat_d;
  logic                  mvld_q, mvld_d;
  logic                  run_q;
  logic                  cmd_rdy;

  // run_q keeps tready low until the first edge after reset release.
  assign cmd_rdy       = (state_q == IDLE) && !mvld_q && run_q;
  assign s_axis.tready = cmd_rdy;
  assign m_axis.tdata  = mdat_q;
  assign m_axis.tvalid = mvld_q;
  assign spi_csn       = csn_q;
  assign spi_sck       = sck_q;
  assign spi_sdo       = sdo_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    csn_d   = csn_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    mdat_d  = mdat_q;
    mvld_d  = mvld_q;

    if (mvld_q && m_axis.tready) mvld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_axis.tvalid && cmd_rdy) begin
          state_d = SETUP;
          tx_d    = s_axis.tdata[DATA_WIDTH-2:0];
          rd_d    = s_axis.tdata[DATA_WIDTH-1];
          sdo_d   = s_axis.tdata[DATA_WIDTH-1];
          rx_d    = '0;
          csn_d   = 1'b0;
          sck_d   = 1'b0;
          tmr_d   = TW'(CS_SETUP - 1);
        end
      end
      SETUP: begin
        if (tmr_q == '0) begin
          state_d = SHIFT;
          ph_d    = PW'(CLK_DIV - 1);
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      SHIFT: begin
        if (ph_q == '0) begin
          ph_d  = PW'(CLK_DIV - 1);
          sck_d = ~sck_q;
          if (!sck_q) begin
            // SDI has been stable since the previous falling edge.
            rx_d = {rx_q[DATA_WIDTH-2:0], spi_sdi};
          end else if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = HOLD;
            tmr_d   = TW'(CS_HOLD - 1);
          end else begin
            bit_d = bit_q + 1'b1;
            sdo_d = tx_q[DATA_WIDTH-2];
            tx_d  = tx_q << 1;
          end
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = GAP;
          csn_d   = 1'b1;
          sdo_d   = 1'b0;
          tmr_d   = TW'(CS_IDLE - 1);
          if (rd_q) begin
            mdat_d = rx_q;
            mvld_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      mdat_q  <= '0;
      mvld_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      mdat_q  <= mdat_d;
      mvld_q  <= mvld_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_spi_cfg_tx.sv
// Bench for axis_spi_cfg_tx: frame-timing model checked every cycle, SPI slave emulation, directed and random commands.
module tb_axis_spi_cfg_tx;
  localparam int DW  = 24;
  localparam int CD  = 2;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int CSI = 4;
  localparam int NSH = 2 * CD * DW;
  localparam int L   = CSS + NSH + CSH;
  localparam int F   = L + CSI;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic spi_csn, spi_sck, spi_sdo;
  logic spi_sdi = 1'b0;

  axis_spi_cfg_tx_if #(.DATA_WIDTH(DW)) s_if();
  axis_spi_cfg_tx_if #(.DATA_WIDTH(DW)) m_if();

  axis_spi_cfg_tx #(
    .DATA_WIDTH(DW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .spi_csn (spi_csn),
    .spi_sck (spi_sck),
    .spi_sdo (spi_sdo),
    .spi_sdi (spi_sdi)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd = 0;
  logic [DW-1:0] sdi_next = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: frame position k counts cycles since the accepting handshake.
  bit            act = 0;
  bit            mv_e = 0;
  int            k = 0;
  int            rcnt = 0;
  logic [DW-1:0] fw = '0;
  logic [DW-1:0] fs = '0;
  logic [DW-1:0] md_e = '0;

  always @(negedge aclk) begin
    logic ecsn, esck, esdo, etr;
    bit   starting;
    int   j;
    if (!aresetn) begin
      chk1("rst_csn", spi_csn, 1'b1);
      chk1("rst_sck", spi_sck, 1'b0);
      chk1("rst_sdo", spi_sdo, 1'b0);
      chk1("rst_s_tready", s_if.tready, 1'b0);
      chk1("rst_m_tvalid", m_if.tvalid, 1'b0);
      chkw("rst_m_tdata", m_if.tdata, '0);
      act = 0; mv_e = 0; rcnt = 0;
    end else begin
      ecsn = 1'b1; esck = 1'b0; esdo = 1'b0;
      if (act) begin
        if (k <= L) ecsn = 1'b0;
        if (k <= CSS) begin
          esdo = fw[DW-1];
        end else if (k <= CSS + NSH) begin
          j = k - CSS - 1;
          esck = ((j / CD) % 2) == 1;
          esdo = fw[DW-1-j/(2*CD)];
        end else if (k <= L) begin
          esdo = fw[0];
        end
      end
      etr = !act && !mv_e && rcnt >= 1;
      chk1("csn", spi_csn, ecsn);
      chk1("sck", spi_sck, esck);
      chk1("sdo", spi_sdo, esdo);
      chk1("s_tready", s_if.tready, etr);
      chk1("m_tvalid", m_if.tvalid, mv_e);
      if (mv_e) chkw("m_tdata", m_if.tdata, md_e);

      starting = etr && s_if.tvalid;
      if (mv_e && m_if.tready) mv_e = 0;
      if (act) begin
        if (k == L && fw[DW-1]) begin
          mv_e = 1;
          md_e = fs;
        end
        k++;
        if (k > F) act = 0;
      end
      if (starting) begin
        act = 1; k = 1; fw = s_if.tdata; fs = sdi_next;
      end
      rcnt++;
    end
  end

  // SPI slave: first bit on CSN fall, next bit after each SCK fall.
  logic [DW-1:0] sdi_sr = '0;
  logic csn_p = 1'b1;
  logic sck_p = 1'b0;
  always @(spi_csn or spi_sck) begin
    if (csn_p && !spi_csn) sdi_sr = fs;
    else if (!spi_csn && sck_p && !spi_sck) sdi_sr = sdi_sr << 1;
    csn_p = spi_csn;
    sck_p = spi_sck;
    spi_sdi = spi_csn ? 1'b0 : sdi_sr[DW-1];
  end

  logic [DW-1:0] cap_sdo = '0;
  int cap_n = 0;
  always @(posedge spi_sck or negedge spi_csn) begin
    if (spi_sck) begin
      cap_sdo = {cap_sdo[DW-2:0], spi_sdo};
      cap_n++;
    end else begin
      cap_sdo = '0;
      cap_n = 0;
    end
  end

  int hi_run = 0, gap_len = -1, lo_run = 0, setup_len = -1;
  bit sck_seen = 0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      hi_run = 0; gap_len = -1; lo_run = 0; setup_len = -1; sck_seen = 0;
    end else if (spi_csn) begin
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        gap_len = hi_run; hi_run = 0; lo_run = 0; sck_seen = 0;
      end
      if (!sck_seen && spi_sck) begin
        setup_len = lo_run;
        sck_seen = 1;
      end
      lo_run++;
    end
  end

  always @(posedge aclk) begin
    if (rnd) begin
      #1;
      m_if.tready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [DW-1:0] w, input logic [DW-1:0] sd, output int hs);
    int n;
    n = 0;
    @(posedge aclk); #1;
    sdi_next = sd; s_if.tdata = w; s_if.tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_if.tready || n > 3000) break;
      n++;
    end
    chk1("send_handshake_bound", s_if.tready, 1'b1);
    hs = cyc;
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_rdy(output bit saw);
    int n;
    n = 0; saw = 0;
    forever begin
      @(negedge aclk);
      if (m_if.tvalid) saw = 1;
      if (s_if.tready || n > 3000) break;
      n++;
    end
    chk1("wait_ready_bound", s_if.tready, 1'b1);
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    forever begin
      @(negedge aclk);
      if (m_if.tvalid || n > 3000) break;
      n++;
    end
    chk1("wait_valid_bound", m_if.tvalid, 1'b1);
  endtask

  initial begin
    int hs, n;
    bit saw;
    logic [DW-1:0] w, sd;
    s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk); chk1("tready_before_first_edge", s_if.tready, 1'b0);
    @(negedge aclk); chk1("tready_after_first_edge", s_if.tready, 1'b1);

    // Write frame: bit order, pulse count, turnaround, no readback.
    send(24'h0A5A5A, 24'h123456, hs);
    wait_rdy(saw);
    chki("wr_turnaround", cyc - hs, 105);
    chkw("wr_sdo_bits", cap_sdo, 24'h0A5A5A);
    chki("wr_sck_pulses", cap_n, 24);
    chk1("wr_no_readback", saw, 1'b0);

    // Read frame with readback held off.
    m_if.tready = 1'b0;
    send(24'h812300, 24'h00BEEF, hs);
    wait_vld();
    chki("rd_valid_latency", cyc - hs, 101);
    chkw("rd_data", m_if.tdata, 24'h00BEEF);

    @(posedge aclk); #1;
    sdi_next = 24'hC0FFEE; s_if.tdata = 24'h9ABCDE; s_if.tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      chk1("held_s_tready", s_if.tready, 1'b0);
      chkw("held_m_tdata", m_if.tdata, 24'h00BEEF);
    end
    @(posedge aclk); #1 m_if.tready = 1'b1;
    @(negedge aclk); chk1("readback_hs_cycle_no_accept", s_if.tready, 1'b0);
    @(posedge aclk); #1 m_if.tready = 1'b0;
    @(negedge aclk); chk1("accept_after_readback", s_if.tready, 1'b1);
    hs = cyc;
    @(posedge aclk); #1 s_if.tvalid = 1'b0;
    wait_vld();
    chki("rd2_valid_latency", cyc - hs, 101);
    chkw("rd2_data", m_if.tdata, 24'hC0FFEE);
    @(posedge aclk); #1 m_if.tready = 1'b1;

    // Reset at the 10th SCK rising edge of a read frame.
    send(24'h800001, 24'h777777, hs);
    n = 0;
    while (cap_n < 10 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    chki("tenth_sck_rise_bound", cap_n, 10);
    #1 aresetn = 1'b0;
    @(negedge aclk);
    chk1("abort_csn", spi_csn, 1'b1);
    chk1("abort_sck", spi_sck, 1'b0);
    chk1("abort_m_tvalid", m_if.tvalid, 1'b0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    wait_rdy(saw);
    chk1("abort_no_readback", saw, 1'b0);
    send(24'h855555, 24'h5A0F3C, hs);
    wait_vld();
    chki("post_reset_latency", cyc - hs, 101);
    chkw("post_reset_data", m_if.tdata, 24'h5A0F3C);

    // Back-to-back commands.
    send(24'h012345, 24'h000000, hs);
    send(24'h0ABCDE, 24'h000000, hs);
    wait_rdy(saw);
    chki("b2b_csn_high_gap", gap_len, CSI + 1);
    chki("csn_to_first_sck", setup_len, CSS + CD);

    // Random commands with random readback backpressure.
    rnd = 1;
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      w  = DW'($urandom);
      sd = DW'($urandom);
      send(w, sd, hs);
    end
    rnd = 0;
    @(posedge aclk); #2 m_if.tready = 1'b1;
    wait_rdy(saw);
    repeat (5) @(negedge aclk);
    chk1("drained_m_tvalid", m_if.tvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_spi_cfg_tx.md
AXIS_SPI_CFG_TX -- requirements
Module: axis_spi_cfg_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 24: SPI command word length in bits; SHALL be ≥ 2.
REQ-002 Parameter CLK_DIV, default 2: SCK half-period in aclk cycles; SHALL be ≥ 1.
REQ-003 Parameters CS_SETUP, default 2; CS_HOLD, default 2; CS_IDLE, default 4: CSN setup, CSN hold and inter-frame gap in aclk cycles; each SHALL be ≥ 1.
REQ-004 aclk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 s_axis_tdata  in  DATA_WIDTH  command word; MSB = read flag (1 = read).
REQ-007 s_axis_tvalid / s_axis_tready  in / out  1 / 1  command handshake.
REQ-008 m_axis_tdata / m_axis_tvalid / m_axis_tready  out / out / in  DATA_WIDTH / 1 / 1  readback word handshake.
REQ-009 spi_csn / spi_sck / spi_sdo  out / out / out  1 / 1 / 1  SPI chip-select, clock and data out, all registered.
REQ-010 spi_sdi  in  1  SPI data in from the ADC.

Function
REQ-011 Protocol SHALL be SPI mode 0: SCK idles low; SDO changes only while SCK is low; SDI is sampled on SCK rising edges; transmission is MSB first.
REQ-012 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-013 s_axis_tready SHALL be 1 only in IDLE while no readback word is pending (m_axis_tvalid = 0).
REQ-014 IDLE -> SETUP on s_axis_tvalid & s_axis_tready: latch tdata into the TX shift register; latch the read flag; clear the RX shift register.
REQ-015 SETUP: csn = 0; sdo = TX MSB; sck = 0; lasts CS_SETUP cycles, then -> SHIFT.
REQ-016 SHIFT: sck SHALL toggle every CLK_DIV cycles, giving exactly DATA_WIDTH rising edges.
REQ-017 SHIFT, each rising edge: shift spi_sdi into the RX LSB.
REQ-018 SHIFT, each falling edge except the last: present the next TX bit on sdo.
REQ-019 SHIFT -> HOLD after the DATA_WIDTH-th falling edge; sck SHALL then be 0.
REQ-020 HOLD: csn stays 0 for CS_HOLD cycles; then csn = 1, sdo = 0, -> GAP.
REQ-021 GAP: lasts CS_IDLE cycles with csn = 1, then -> IDLE.
REQ-022 On GAP entry, if the read flag is set: m_axis_tdata = RX word (first sampled bit in the MSB) and m_axis_tvalid = 1; write commands SHALL produce no output.
REQ-023 m_axis_tvalid SHALL hold with stable tdata until the cycle m_axis_tready = 1, then clear; while held, no new command SHALL be accepted.
REQ-024 Bit and phase counters SHALL be sized as clog2(DATA_WIDTH)+1 and clog2(CLK_DIV)+1 bits.
REQ-025 s_axis_tvalid arriving outside IDLE SHALL be ignored until s_axis_tready is asserted.
REQ-026 Simultaneous m_axis_tready with GAP entry SHALL not drop the new word; tvalid rises and clears on a later handshake.
REQ-027 Timing: with the handshake at cycle 0, csn SHALL fall at cycle 1, and s_axis_tready SHALL next be 1 at cycle CS_SETUP + 2*CLK_DIV*DATA_WIDTH + CS_HOLD + CS_IDLE + 1.

Reset
REQ-028 While aresetn = 0 all outputs SHALL be: csn = 1, sck = 0, sdo = 0, s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0; state = IDLE; counters cleared.
REQ-029 Reset asserted mid-frame SHALL abort immediately, without completing SCK pulses or emitting readback.
REQ-030 s_axis_tready SHALL rise on the first aclk edge after aresetn deasserts.

Verification
REQ-031 Write 0x0A5A5A (DATA_WIDTH = 24, CLK_DIV = 2) -> 24 SCK pulses; SDO bits 000010100101101001011010; no m_axis output; tready back after 105 cycles.
REQ-032 Read 0x812300 with SDI model returning 0x00BEEF -> m_axis_tdata = 0x00BEEF, tvalid = 1 at GAP entry.
REQ-033 Hold m_axis_tready = 0 for 50 cycles after the read in REQ-032, with a second command valid -> tready stays 0 and data stays stable; accepted one cycle after the readback handshake.
REQ-034 Assert aresetn = 0 at the 10th SCK rising edge -> csn = 1, sck = 0 within the reset, no tvalid; the next command executes normally.
REQ-035 Back-to-back tvalid with CS_IDLE = 4 -> measured csn-high gap is exactly CS_IDLE + 1 cycles; csn-to-first-SCK-rise is CS_SETUP + CLK_DIV cycles.
